// File: rtl/int_wb_pipereg.sv
// Writeback pipeline register after the integer execute block.
// Registers the per-instruction result toward the PRF and ROB, turns a
// captured mispredict into a one-cycle backend flush pulse, and holds the
// oldest outstanding frontend redirect until fetch accepts it.
// Instructions younger than an active flush are dropped on capture.
module int_wb_pipereg #(
  parameter int ROBID_W = 7,
  parameter int SQID_W  = 5,
  parameter int PREG_W  = 6
) (
  input  logic               clock,
  input  logic               reset,

  input  logic               in_instr_valid,
  input  logic               in_need_to_wb,
  input  logic               in_redirect_valid,
  input  logic [PREG_W-1:0]  in_prd,
  input  logic [63:0]        in_result,
  input  logic [63:0]        in_redirect_target,
  input  logic [ROBID_W-1:0] in_robid,
  input  logic [SQID_W-1:0]  in_sqid,
  input  logic [63:0]        in_pc,
  input  logic [31:0]        in_instr,

  input  logic               ext_flush_valid,
  input  logic [ROBID_W-1:0] ext_flush_robid,

  output logic               wb_valid,
  output logic               wb_need_to_wb,
  output logic [PREG_W-1:0]  wb_prd,
  output logic [63:0]        wb_result,
  output logic [ROBID_W-1:0] wb_robid,
  output logic [SQID_W-1:0]  wb_sqid,
  output logic [63:0]        wb_pc,
  output logic [31:0]        wb_instr,

  output logic               flush_valid,
  output logic [ROBID_W-1:0] flush_robid,
  output logic [63:0]        flush_target,

  output logic               fe_redirect_valid,
  output logic [63:0]        fe_redirect_target,
  output logic [ROBID_W-1:0] fe_redirect_robid,
  input  logic               fe_redirect_ready,

  output logic [31:0]        redirect_cnt
);

  // True when a is strictly older than b. The MSB is the ROB wrap flag, so a
  // differing flag inverts the index comparison. Equal ids are not older.
  function automatic logic older(input logic [ROBID_W-1:0] a,
                                 input logic [ROBID_W-1:0] b);
    older = (a[ROBID_W-1] ^ b[ROBID_W-1]) ^ (a[ROBID_W-2:0] < b[ROBID_W-2:0]);
  endfunction

  logic               kill;
  logic               cap_redirect;
  logic               pend_accept;
  logic               pend_load;
  logic               pend_valid_nxt;
  logic [63:0]        pend_target_nxt;
  logic [ROBID_W-1:0] pend_robid_nxt;

  // Kill decision for the incoming instruction and pending-entry update.
  always_comb begin
    pend_valid_nxt  = fe_redirect_valid;
    pend_target_nxt = fe_redirect_target;
    pend_robid_nxt  = fe_redirect_robid;

    kill = (flush_valid     && older(flush_robid, in_robid)) ||
           (ext_flush_valid && older(ext_flush_robid, in_robid));
    cap_redirect = in_instr_valid && in_redirect_valid && !kill;
    pend_accept  = fe_redirect_ready && fe_redirect_valid;
    // A captured redirect has already survived both flush sources, so a load
    // takes priority over an external flush of the old pending entry.
    pend_load    = cap_redirect &&
                   (!fe_redirect_valid || pend_accept ||
                    older(in_robid, fe_redirect_robid));

    if (pend_load) begin
      pend_valid_nxt  = 1'b1;
      pend_target_nxt = in_redirect_target;
      pend_robid_nxt  = in_robid;
    end else if (pend_accept) begin
      pend_valid_nxt  = 1'b0;
    end else if (ext_flush_valid && older(ext_flush_robid, fe_redirect_robid)) begin
      pend_valid_nxt  = 1'b0;
    end
  end

  // Writeback bundle: valids are kill-filtered, payload loads every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid      <= 1'b0;
      wb_need_to_wb <= 1'b0;
      wb_prd        <= '0;
      wb_result     <= '0;
      wb_robid      <= '0;
      wb_sqid       <= '0;
      wb_pc         <= '0;
      wb_instr      <= '0;
    end else begin
      wb_valid      <= in_instr_valid && !kill;
      wb_need_to_wb <= in_need_to_wb && in_instr_valid && !kill;
      wb_prd        <= in_prd;
      wb_result     <= in_result;
      wb_robid      <= in_robid;
      wb_sqid       <= in_sqid;
      wb_pc         <= in_pc;
      wb_instr      <= in_instr;
    end
  end

  // One-cycle flush pulse; id and target hold between redirects.
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_valid  <= 1'b0;
      flush_robid  <= '0;
      flush_target <= '0;
    end else begin
      flush_valid <= cap_redirect;
      if (cap_redirect) begin
        flush_robid  <= in_robid;
        flush_target <= in_redirect_target;
      end
    end
  end

  // Pending frontend redirect entry, driven straight onto the fe_* outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      fe_redirect_valid  <= 1'b0;
      fe_redirect_target <= '0;
      fe_redirect_robid  <= '0;
    end else begin
      fe_redirect_valid  <= pend_valid_nxt;
      fe_redirect_target <= pend_target_nxt;
      fe_redirect_robid  <= pend_robid_nxt;
    end
  end

  // PMU count of flush pulses, wrapping naturally at 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      redirect_cnt <= '0;
    end else if (flush_valid) begin
      redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_int_wb_pipereg.sv
// Directed bench for int_wb_pipereg: linear stimulus, hand-computed expectations.
module tb_int_wb_pipereg;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_instr_valid, in_need_to_wb, in_redirect_valid;
  logic [5:0]  in_prd;
  logic [63:0] in_result, in_redirect_target, in_pc;
  logic [6:0]  in_robid;
  logic [4:0]  in_sqid;
  logic [31:0] in_instr;
  logic        ext_flush_valid;
  logic [6:0]  ext_flush_robid;
  logic        wb_valid, wb_need_to_wb;
  logic [5:0]  wb_prd;
  logic [63:0] wb_result, wb_pc;
  logic [6:0]  wb_robid;
  logic [4:0]  wb_sqid;
  logic [31:0] wb_instr;
  logic        flush_valid;
  logic [6:0]  flush_robid;
  logic [63:0] flush_target;
  logic        fe_redirect_valid;
  logic [63:0] fe_redirect_target;
  logic [6:0]  fe_redirect_robid;
  logic        fe_redirect_ready;
  logic [31:0] redirect_cnt;

  int errors = 0;
  int checks = 0;

  int_wb_pipereg dut (
    .clock(clock), .reset(reset),
    .in_instr_valid(in_instr_valid), .in_need_to_wb(in_need_to_wb),
    .in_redirect_valid(in_redirect_valid), .in_prd(in_prd),
    .in_result(in_result), .in_redirect_target(in_redirect_target),
    .in_robid(in_robid), .in_sqid(in_sqid), .in_pc(in_pc), .in_instr(in_instr),
    .ext_flush_valid(ext_flush_valid), .ext_flush_robid(ext_flush_robid),
    .wb_valid(wb_valid), .wb_need_to_wb(wb_need_to_wb), .wb_prd(wb_prd),
    .wb_result(wb_result), .wb_robid(wb_robid), .wb_sqid(wb_sqid),
    .wb_pc(wb_pc), .wb_instr(wb_instr),
    .flush_valid(flush_valid), .flush_robid(flush_robid), .flush_target(flush_target),
    .fe_redirect_valid(fe_redirect_valid), .fe_redirect_target(fe_redirect_target),
    .fe_redirect_robid(fe_redirect_robid), .fe_redirect_ready(fe_redirect_ready),
    .redirect_cnt(redirect_cnt)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_instr_valid     = 1'b0;
    in_need_to_wb      = 1'b0;
    in_redirect_valid  = 1'b0;
    in_prd             = '0;
    in_result          = '0;
    in_redirect_target = '0;
    in_robid           = '0;
    in_sqid            = '0;
    in_pc              = '0;
    in_instr           = '0;
    ext_flush_valid    = 1'b0;
    ext_flush_robid    = '0;
    fe_redirect_ready  = 1'b0;
  endtask

  task automatic drive(input logic [6:0] robid, input logic redir, input logic [63:0] tgt);
    in_instr_valid     = 1'b1;
    in_need_to_wb      = 1'b0;
    in_redirect_valid  = redir;
    in_robid           = robid;
    in_redirect_target = tgt;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_flush_valid", flush_valid, 0);
    check("rst_fe_valid", fe_redirect_valid, 0);
    check("rst_cnt", redirect_cnt, 0);
    reset = 1'b0;

    // Plain writeback
    drive(7'h05, 1'b0, 64'h0);
    in_need_to_wb = 1'b1;
    in_prd        = 6'd12;
    in_result     = 64'h1234;
    in_sqid       = 5'd3;
    in_pc         = 64'h8000_0040;
    in_instr      = 32'h0000_0013;
    step();
    check("wb_valid", wb_valid, 1);
    check("wb_need", wb_need_to_wb, 1);
    check("wb_prd", wb_prd, 12);
    check("wb_result", wb_result, 64'h1234);
    check("wb_robid", wb_robid, 7'h05);
    check("wb_sqid", wb_sqid, 3);
    check("wb_pc", wb_pc, 64'h8000_0040);
    check("wb_instr", wb_instr, 32'h13);
    check("wb_no_flush", flush_valid, 0);
    idle();
    step();
    check("wb_idle", wb_valid, 0);

    // Redirect with slow fetch
    drive(7'h10, 1'b1, 64'h8000_1000);
    step();
    check("rd_flush_valid", flush_valid, 1);
    check("rd_flush_robid", flush_robid, 7'h10);
    check("rd_flush_tgt", flush_target, 64'h8000_1000);
    check("rd_fe_valid1", fe_redirect_valid, 1);
    check("rd_fe_tgt", fe_redirect_target, 64'h8000_1000);
    idle();
    step();
    check("rd_pulse_end", flush_valid, 0);
    check("rd_fe_valid2", fe_redirect_valid, 1);
    check("rd_cnt", redirect_cnt, 1);
    step();
    check("rd_fe_valid3", fe_redirect_valid, 1);
    check("rd_flush_hold", flush_robid, 7'h10);
    fe_redirect_ready = 1'b1;
    step();
    check("rd_fe_cleared", fe_redirect_valid, 0);
    idle();

    // Younger instruction killed by the flush pulse; the same id survives
    drive(7'h10, 1'b1, 64'h8000_2000);
    step();
    drive(7'h11, 1'b0, 64'h0);
    step();
    check("kill_younger", wb_valid, 0);
    idle();
    drive(7'h10, 1'b1, 64'h8000_2000);
    step();
    drive(7'h10, 1'b0, 64'h0);
    step();
    check("keep_same_id", wb_valid, 1);
    idle();
    fe_redirect_ready = 1'b1;
    step();
    check("kill_fe_clear", fe_redirect_valid, 0);
    check("kill_cnt", redirect_cnt, 3);
    idle();

    // Wrap-around: pending 0x7E is older than new 0x02
    drive(7'h7E, 1'b1, 64'h7E00);
    step();
    idle();
    step();
    drive(7'h02, 1'b1, 64'h0200);
    step();
    check("wrap_pulse", flush_valid, 1);
    check("wrap_pulse_id", flush_robid, 7'h02);
    check("wrap_keep_old", fe_redirect_robid, 7'h7E);
    check("wrap_keep_tgt", fe_redirect_target, 64'h7E00);
    idle();
    fe_redirect_ready = 1'b1;
    step();
    idle();
    drive(7'h02, 1'b1, 64'h0200);
    step();
    idle();
    step();
    check("wrap_pend02", fe_redirect_robid, 7'h02);
    drive(7'h7E, 1'b1, 64'h7E00);
    step();
    check("wrap_replace", fe_redirect_robid, 7'h7E);
    check("wrap_replace_tgt", fe_redirect_target, 64'h7E00);
    idle();
    fe_redirect_ready = 1'b1;
    step();
    idle();
    check("wrap_cnt", redirect_cnt, 7);

    // External flush clears an older-than-pending entry and kills younger capture
    drive(7'h0A, 1'b1, 64'h0A00);
    step();
    idle();
    step();
    check("ext_pend_set", fe_redirect_valid, 1);
    ext_flush_valid = 1'b1;
    ext_flush_robid = 7'h08;
    drive(7'h09, 1'b0, 64'h0);
    step();
    check("ext_pend_clear", fe_redirect_valid, 0);
    check("ext_kill", wb_valid, 0);
    drive(7'h08, 1'b0, 64'h0);
    step();
    check("ext_keep_same", wb_valid, 1);
    idle();
    // Same-cycle qualifying load beats the external flush
    drive(7'h0A, 1'b1, 64'h0A00);
    step();
    idle();
    step();
    ext_flush_valid = 1'b1;
    ext_flush_robid = 7'h08;
    drive(7'h08, 1'b1, 64'h0800);
    step();
    check("ext_load_wins", fe_redirect_valid, 1);
    check("ext_load_id", fe_redirect_robid, 7'h08);
    idle();
    fe_redirect_ready = 1'b1;
    step();
    idle();

    // Reset while pending and flush pulse active
    drive(7'h20, 1'b1, 64'h2000);
    step();
    check("pre_rst_flush", flush_valid, 1);
    check("pre_rst_cnt", redirect_cnt, 10);
    idle();
    reset = 1'b1;
    step();
    check("mid_rst_wb", wb_valid, 0);
    check("mid_rst_flush", flush_valid, 0);
    check("mid_rst_fe", fe_redirect_valid, 0);
    check("mid_rst_cnt", redirect_cnt, 0);
    reset = 1'b0;
    step();
    check("post_rst_fe", fe_redirect_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_wb_pipereg.md
# int_wb_pipereg

Writeback pipeline register downstream of the integer execute block (ALU/BJU/MULDIV). It registers the execute block's per-instruction result toward the physical register file and ROB, and turns a branch/jump mispredict into a one-cycle backend flush broadcast that feeds back to the execute block's `flush_valid`/`flush_robid` inputs. It also holds the oldest outstanding frontend redirect until the fetch unit accepts it. Instructions younger than any active flush are dropped on capture.

## Interface
Parameters:
- `ROBID_W`, 7: ROB id width; MSB is the wrap flag, low `ROBID_W-1` bits are the index.
- `SQID_W`, 5: store-queue id width, i.e. `STOREQUEUE_SIZE_LOG+1`.
- `PREG_W`, 6: physical register index width.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_instr_valid`, `in_need_to_wb`, `in_redirect_valid` in 1 each: from the execute block.
- `in_prd` in PREG_W; `in_result` in 64; `in_redirect_target` in 64; `in_robid` in ROBID_W; `in_sqid` in SQID_W; `in_pc` in 64; `in_instr` in 32: from the execute block.
- `ext_flush_valid` in 1, `ext_flush_robid` in ROBID_W: flush from other backend sources (memory pipe, commit).
- `wb_valid`, `wb_need_to_wb` out 1 each; `wb_prd` out PREG_W; `wb_result` out 64; `wb_robid` out ROBID_W; `wb_sqid` out SQID_W; `wb_pc` out 64; `wb_instr` out 32: registered writeback bundle to the PRF, ROB and debug.
- `flush_valid` out 1, `flush_robid` out ROBID_W, `flush_target` out 64: one-cycle flush broadcast to the execute block and backend.
- `fe_redirect_valid` out 1, `fe_redirect_target` out 64, `fe_redirect_robid` out ROBID_W: held redirect to fetch.
- `fe_redirect_ready` in 1: fetch accepts the redirect.
- `redirect_cnt` out 32: PMU count of flush pulses.

## Operation
- **Age compare.** `older(a,b) = (a[MSB]^b[MSB]) ^ (a[MSB-1:0] < b[MSB-1:0])`, with MSB = ROBID_W-1. A robid equal to the flush robid is not younger; the redirecting instruction itself survives.
- **Kill on capture.** An incoming instruction is killed if either holds:
  - `flush_valid` is high and `older(flush_robid, in_robid)`;
  - `ext_flush_valid` is high and `older(ext_flush_robid, in_robid)`.
- **Writeback register.** Every cycle, `wb_valid` is loaded with `in_instr_valid & ~kill`. All payload registers load unconditionally. `wb_need_to_wb` is loaded as `in_need_to_wb & in_instr_valid & ~kill`.
- **Flush pulse.** Next-cycle `flush_valid` is `in_instr_valid & in_redirect_valid & ~kill`. When set, `flush_robid`/`flush_target` load `in_robid`/`in_redirect_target`; otherwise they hold. `flush_valid` is high for exactly one cycle per redirect.
- **Pending frontend redirect.** A single entry with valid bit P; the `fe_redirect_*` outputs come directly from it.
  - Load: a captured redirect loads the entry if P=0, if P=1 and `older(in_robid, pending_robid)`, or if the pending entry is being accepted this cycle (`fe_redirect_ready & P`).
  - Discard: if P=1 and the new redirect is not older, the new redirect is discarded for frontend purposes. Its flush pulse is still issued.
  - Accept: `fe_redirect_ready & P` with no load clears P.
  - External flush: `ext_flush_valid & older(ext_flush_robid, pending_robid)` clears P. A same-cycle qualifying load still wins, since it was already age-filtered against the external flush.
- **Counter.** `redirect_cnt` increments by 1 on each cycle `flush_valid` is high and wraps at 2^32.
- **Reset.** `wb_valid`, `wb_need_to_wb`, `flush_valid`, P and `redirect_cnt` go to 0. All other registers go to 0 as well.

## Timing
- Writeback latency is 1: inputs in cycle N produce `wb_*` in N+1.
- Flush latency is 1: a redirect captured in N gives `flush_valid` in N+1. That pulse kills captures in N+1 that are strictly younger than it.
- Frontend redirect: visible in N+1. It stays stable while P=1 and `fe_redirect_ready`=0 unless replaced by an older one.
- Back-to-back redirects: if N has an older redirect and N+1 a younger one, the N+1 capture is killed by the N+1 flush pulse. If the N+1 redirect is older, it pulses again in N+2 and replaces the pending entry.
- Robid wrap (MSB differs): ordering is inverted per the age formula.
- Reset asserted mid-operation: all valids are 0 in the following cycle. An in-flight pending redirect is lost.
- There is no backpressure toward the execute block; the stage accepts every cycle.

## Test plan
- **Plain writeback.** `in_instr_valid`=1, robid=0x05, prd=12, result=0x1234, no redirect → next cycle `wb_valid`=1, `wb_prd`=12, `wb_result`=0x1234, `flush_valid`=0.
- **Redirect with slow fetch.** Redirect robid=0x10, target=0x80001000, `fe_redirect_ready`=0 for 3 cycles → `flush_valid` pulses one cycle; `fe_redirect_valid` is held for 3 cycles, then clears the cycle after ready=1; `redirect_cnt`=1.
- **Younger instruction killed.** Redirect robid=0x10 in N; robid=0x11 valid in N+1 → `wb_valid`=0 in N+2. Robid=0x10 in N+1 is kept.
- **Wrap-around replacement.** Pending robid=0x7E; a new redirect robid=0x02 (MSB differs, so 0x7E is older) is not loaded. Pending 0x02 with new 0x7E: the pending entry is replaced by 0x7E.
- **External flush.** `ext_flush_robid`=0x08 with pending robid=0x0A → P clears. In the same cycle, an incoming robid=0x09 → `wb_valid`=0 next cycle.
- **Reset mid-pending.** `reset`=1 while P=1 and `flush_valid`=1 → next cycle all valids are 0 and `redirect_cnt`=0.
